// File: rtl/thread_fetch_scheduler.sv
// thread_fetch_scheduler: two-thread fetch-slot picker with park/redirect/halt handling.
// Optional THREAD_FETCH_PERF_EN adds per-thread issue and idle-cycle counters.
module thread_fetch_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC0 = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC1 = 32'h0000_1000,
  parameter int QUANTUM = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_block_valid,
  input  logic                  i_block_tid,
  input  logic                  i_resolve_valid,
  input  logic                  i_resolve_tid,
  input  logic                  i_resolve_redirect,
  input  logic [ADDR_WIDTH-1:0] i_resolve_target,
  input  logic                  i_done_valid,
  input  logic                  i_done_tid,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_thread_id,
  output logic                  o_all_halted
`ifdef THREAD_FETCH_PERF_EN
  ,
  output logic [31:0]           o_fetch_cnt0,
  output logic [31:0]           o_fetch_cnt1,
  output logic [31:0]           o_idle_cnt
`endif
);
  typedef enum logic [1:0] {RUN, BLOCKED, HALTED} st_e;
  localparam logic [3:0] QMAX = 4'(QUANTUM);
  st_e st_q [2];
  logic [ADDR_WIDTH-1:0] pc_q [2];
  logic [ADDR_WIDTH-1:0] hold_q;
  logic last_q, tid_q;
  logic [3:0] cnt_q;
  logic [1:0] elig, done_hit, blk_hit, res_hit;
  logic stay, sel, valid, issue;
  always_comb begin
    done_hit = {i_done_valid && i_done_tid, i_done_valid && !i_done_tid};
    blk_hit = {i_block_valid && i_block_tid, i_block_valid && !i_block_tid};
    res_hit = {i_resolve_valid && i_resolve_tid, i_resolve_valid && !i_resolve_tid};
    elig[0] = st_q[0] == RUN && !blk_hit[0] && !done_hit[0];
    elig[1] = st_q[1] == RUN && !blk_hit[1] && !done_hit[1];
    // a zero count means last_q has not fetched yet (post-reset), so it gets no stickiness
    stay = elig[last_q] && cnt_q != 4'd0 && cnt_q < QMAX;
    sel = stay ? last_q : (elig[!last_q] ? !last_q : last_q);
    valid = !rst && |elig;
    issue = valid && !i_stall;
  end
  assign o_valid = valid;
  assign o_pc = rst ? '0 : (valid ? pc_q[sel] : hold_q);
  assign o_thread_id = rst ? 1'b0 : (valid ? sel : tid_q);
  assign o_all_halted = !rst && st_q[0] == HALTED && st_q[1] == HALTED;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q[0] <= RESET_PC0;
      pc_q[1] <= RESET_PC1;
      st_q[0] <= RUN;
      st_q[1] <= RUN;
      last_q <= 1'b1;
      cnt_q <= 4'd0;
      hold_q <= '0;
      tid_q <= 1'b0;
    end else begin
      if (valid) begin
        hold_q <= pc_q[sel];
        tid_q <= sel;
      end
      if (issue) begin
        last_q <= sel;
        cnt_q <= sel != last_q ? 4'd1 : (cnt_q < QMAX ? cnt_q + 4'd1 : cnt_q);
      end
      for (int t = 0; t < 2; t++) begin
        if (st_q[t] != HALTED) begin
          st_q[t] <= done_hit[t] ? HALTED : blk_hit[t] ? BLOCKED : res_hit[t] ? RUN : st_q[t];
          if (!done_hit[t])
            pc_q[t] <= res_hit[t] && i_resolve_redirect ? {i_resolve_target[ADDR_WIDTH-1:2], 2'b00}
                     : issue && sel == 1'(t) ? pc_q[t] + ADDR_WIDTH'(4) : pc_q[t];
        end
      end
    end
  end
`ifdef THREAD_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_fetch_cnt0 <= '0;
      o_fetch_cnt1 <= '0;
      o_idle_cnt <= '0;
    end else if (!i_stall) begin
      if (issue && !sel) o_fetch_cnt0 <= o_fetch_cnt0 + 32'd1;
      if (issue && sel) o_fetch_cnt1 <= o_fetch_cnt1 + 32'd1;
      if (!valid && !o_all_halted) o_idle_cnt <= o_idle_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// tb_thread_fetch_scheduler: scoreboard bench for QUANTUM=1 and QUANTUM=2 instances sharing stimulus.
module tb_thread_fetch_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, bv = 1'b0, bt = 1'b0, rv = 1'b0, rt = 1'b0, rr = 1'b0, dv = 1'b0, dt = 1'b0;
  logic [31:0] tg = '0;
  logic [1:0] ov, otid, oah;
  logic [1:0][31:0] opc;
`ifdef THREAD_FETCH_PERF_EN
  logic [1:0][31:0] of0, of1, oid;
`endif
  int tests = 0, errs = 0;
  always #5 clk = ~clk;

  thread_fetch_scheduler #(.QUANTUM(1)) u0 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_block_valid(bv), .i_block_tid(bt),
    .i_resolve_valid(rv), .i_resolve_tid(rt), .i_resolve_redirect(rr), .i_resolve_target(tg),
    .i_done_valid(dv), .i_done_tid(dt), .o_valid(ov[0]), .o_pc(opc[0]), .o_thread_id(otid[0]),
    .o_all_halted(oah[0])
`ifdef THREAD_FETCH_PERF_EN
    , .o_fetch_cnt0(of0[0]), .o_fetch_cnt1(of1[0]), .o_idle_cnt(oid[0])
`endif
  );
  thread_fetch_scheduler #(.QUANTUM(2)) u1 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_block_valid(bv), .i_block_tid(bt),
    .i_resolve_valid(rv), .i_resolve_tid(rt), .i_resolve_redirect(rr), .i_resolve_target(tg),
    .i_done_valid(dv), .i_done_tid(dt), .o_valid(ov[1]), .o_pc(opc[1]), .o_thread_id(otid[1]),
    .o_all_halted(oah[1])
`ifdef THREAD_FETCH_PERF_EN
    , .o_fetch_cnt0(of0[1]), .o_fetch_cnt1(of1[1]), .o_idle_cnt(oid[1])
`endif
  );

  typedef struct {
    logic v; logic [31:0] pc; logic tid; logic ah; logic chkp;
    logic [31:0] f0; logic [31:0] f1; logic [31:0] idl;
  } exp_t;
  exp_t sb0[$], sb1[$];

  // reference: per-thread PC and state (0 run, 1 blocked, 2 halted), last fetcher and its run length
  logic [31:0] mpc [2][2];
  int mst [2][2];
  int mlast [2], mcnt [2];
  logic [31:0] mhpc [2];
  logic mhtid [2];
  logic [31:0] mf [2][2];
  logic [31:0] midl [2];

  task automatic model(input int k, output exp_t e);
    int sel;
    bit ok [2];
    bit iss;
    e.chkp = !rst;
    e.f0 = mf[k][0];
    e.f1 = mf[k][1];
    e.idl = midl[k];
    if (rst) begin
      e.v = 0; e.pc = '0; e.tid = 0; e.ah = 0;
      mpc[k][0] = 32'h0; mpc[k][1] = 32'h1000;
      mst[k][0] = 0; mst[k][1] = 0;
      mlast[k] = 1; mcnt[k] = 0;
      mhpc[k] = '0; mhtid[k] = 0;
      mf[k][0] = '0; mf[k][1] = '0; midl[k] = '0;
      return;
    end
    for (int t = 0; t < 2; t++) ok[t] = mst[k][t] == 0 && !(bv && bt == t[0]) && !(dv && dt == t[0]);
    sel = -1;
    if (ok[mlast[k]] && mcnt[k] > 0 && mcnt[k] < k + 1) sel = mlast[k];
    else if (ok[1 - mlast[k]]) sel = 1 - mlast[k];
    else if (ok[mlast[k]]) sel = mlast[k];
    e.v = sel >= 0;
    e.ah = mst[k][0] == 2 && mst[k][1] == 2;
    if (e.v) begin
      mhpc[k] = mpc[k][sel];
      mhtid[k] = sel[0];
    end
    e.pc = mhpc[k];
    e.tid = mhtid[k];
    iss = e.v && !stall;
    if (!stall && !e.v && !e.ah) midl[k]++;
    if (iss) begin
      mf[k][sel]++;
      mcnt[k] = sel == mlast[k] ? mcnt[k] + 1 : 1;
      mlast[k] = sel;
    end
    for (int t = 0; t < 2; t++) begin
      if (mst[k][t] == 2) continue;
      if (dv && dt == t[0]) begin
        mst[k][t] = 2;
        continue;
      end
      if (rv && rt == t[0] && rr) mpc[k][t] = {tg[31:2], 2'b00};
      else if (iss && sel == t) mpc[k][t] = mpc[k][t] + 32'd4;
      if (bv && bt == t[0]) mst[k][t] = 1;
      else if (rv && rt == t[0]) mst[k][t] = 0;
    end
  endtask

  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", n, k, a, x, $time);
    end
  endtask

  task automatic check(input int k, input exp_t e);
    chk("valid", k, 32'(ov[k]), 32'(e.v));
    chk("pc", k, opc[k], e.pc);
    chk("tid", k, 32'(otid[k]), 32'(e.tid));
    chk("all_halted", k, 32'(oah[k]), 32'(e.ah));
`ifdef THREAD_FETCH_PERF_EN
    if (e.chkp) begin
      chk("fetch_cnt0", k, of0[k], e.f0);
      chk("fetch_cnt1", k, of1[k], e.f1);
      chk("idle_cnt", k, oid[k], e.idl);
    end
`endif
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      check(0, e);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check(1, e);
    end
  end

  task automatic go(input bit r, s, bv_, bt_, rv_, rt_, rr_, input logic [31:0] tg_, input bit dv_, dt_);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; bv = bv_; bt = bt_; rv = rv_; rt = rt_; rr = rr_; tg = tg_; dv = dv_; dt = dt_;
    model(0, e);
    sb0.push_back(e);
    model(1, e);
    sb1.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic reset(input int n);
    for (int i = 0; i < n; i++) go(1, 0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    reset(2);
    idle(6);
    go(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    go(0, 1, 0, 0, 0, 0, 0, '0, 0, 0);
    idle(3);
    go(0, 0, 1, 0, 0, 0, 0, '0, 0, 0);
    idle(4);
    go(0, 0, 0, 0, 1, 0, 1, 32'h203, 0, 0);
    idle(3);
    go(0, 0, 1, 0, 0, 0, 0, '0, 0, 0);
    idle(3);
    go(0, 0, 0, 0, 1, 0, 0, 32'h5555, 0, 0);
    idle(3);
    go(0, 0, 1, 1, 1, 1, 1, 32'h80, 0, 0);
    idle(4);
    go(0, 1, 0, 0, 1, 1, 0, '0, 0, 0);
    idle(3);
    go(0, 0, 0, 0, 0, 0, 0, '0, 1, 0);
    idle(2);
    go(0, 0, 0, 0, 0, 0, 0, '0, 1, 1);
    idle(2);
    go(0, 0, 0, 0, 1, 0, 1, 32'h400, 0, 0);
    idle(2);
    reset(1);
    idle(2);
    go(0, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0);
    idle(5);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = $urandom_range(0, 299) == 0 || (mst[0][0] == 2 && mst[0][1] == 2 && $urandom_range(0, 4) == 0);
      go(r, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
         1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 199) == 0, 1'($urandom));
    end
    idle(2);
    repeat (3) @(negedge clk);
    tests++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending expected 0", sb0.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
